// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes difference = (a - b) mod 2^WIDTH
//   and a final borrow, one bit per clock, LSB first. A 1-bit full-subtractor
//   cell feeds a registered borrow flip-flop. Operands are taken on an
//   accepted start, and the result is published on the edge into DONE.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   start       in   1      request; accepted only in IDLE or DONE
//   a           in   WIDTH  minuend, captured on the accepting edge
//   b           in   WIDTH  subtrahend, captured on the accepting edge
//   busy        out  1      high while in SHIFT
//   done        out  1      one-cycle pulse when the result becomes valid
//   difference  out  WIDTH  result, held until the next result is published
//   borrow_out  out  1      final borrow (a < b), held like difference
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_SHIFT | one bit step per cycle, WIDTH cycles
//   S_DONE  | result valid, done=1 for one cycle; start here is accepted

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             bff;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             bout;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] sa_next;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        x    = sa[0];
        y    = sb[0];
        d    = x ^ y ^ bff;
        bout = (~x & y) | (~(x ^ y) & bff);
    end

    // The minuend register doubles as the result register. Each step, the
    // difference bit enters at the MSB end, which the right shift has just
    // vacated. After WIDTH steps the register holds the full result, LSB at bit 0.
    assign sa_next   = {d, sa[WIDTH-1:1]};
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sa         <= '0;
            sb         <= '0;
            bff        <= 1'b0;
            cnt        <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        bff   <= 1'b0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa_next;
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    bff <= bout;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        difference <= sa_next;
                        borrow_out <= bout;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Both flags decode from the registered state only.
    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] difference;
    logic         borrow_out;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit unsigned arithmetic, borrow is the top bit.
    function automatic logic [W:0] model(input logic [W-1:0] va, input logic [W-1:0] vb);
        return {1'b0, va} - {1'b0, vb};
    endfunction

    // One complete operation from IDLE, checking the busy window, the done
    // pulse timing, the result, and that outputs are held afterwards.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb, input string tag);
        logic [W-1:0] prev_d;
        logic         prev_b;
        prev_d = difference;
        prev_b = borrow_out;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            check({tag, " diff_no_partial"}, 32'({borrow_out, difference}), 32'({prev_b, prev_d}));
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(difference), 32'(ed));
        check({tag, " borrow"}, 32'(borrow_out), 32'(eb));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " hold"}, 32'({borrow_out, difference}), 32'({eb, ed}));
    endtask

    initial begin
        logic [W:0]   r;
        logic [W-1:0] a2;
        logic [W-1:0] b2;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(difference), 32'd0);
        check("reset borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, $sformatf("vec%0d", i));

        // start held high through SHIFT with changing operands
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("b2b busy1", 32'(busy), 32'd1);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        check("b2b done1", 32'(done), 32'd1);
        check("b2b diff1", 32'({borrow_out, difference}), 32'h002);
        a2 = W'($urandom);
        b2 = W'($urandom);
        a = a2; b = b2;
        r = model(a2, b2);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("b2b busy2", 32'(busy), 32'd1);
            check("b2b done_gap", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("b2b done2", 32'(done), 32'd1);
        check("b2b diff2", 32'({borrow_out, difference}), 32'(r));
        @(negedge clk);
        check("b2b idle", 32'({busy, done}), 32'd0);

        // reset during the 4th SHIFT cycle, after a nonzero result
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, "pre_rst");
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        check("mid_rst diff", 32'(difference), 32'd0);
        check("mid_rst borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst idle", 32'({busy, done}), 32'd0);
        run_op(8'hAA, 8'h55, 8'h55, 1'b0, "post_rst");

        // randomized operands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            a2 = W'($urandom);
            b2 = W'($urandom);
            if (i % 10 == 0) b2 = a2;
            r = model(a2, b2);
            run_op(a2, b2, r[W-1:0], r[W], $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
